// File: rtl/mouse_pkg.sv
// mouse_pkg: shared screen constants, receiver states, packet bit positions and motion helpers.
// MOUSE_ACCEL_EN doubles deltas larger than 15 counts before they are applied.
package mouse_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int LBTN  = 0;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef struct packed {
    logic yovf;
    logic xovf;
    logic ysign;
    logic xsign;
    logic lbtn;
  } hdr_t;
  function automatic logic signed [10:0] delta(input logic ovf, input logic sgn, input logic [7:0] mag);
    logic signed [10:0] d;
    d = ovf ? 11'sd0 : {{3{sgn}}, mag};
`ifdef MOUSE_ACCEL_EN
    d = (d > 11'sd15 || d < -11'sd15) ? d <<< 1 : d;
`endif
    return d;
  endfunction
  // Sum is carried in 13 bits so an accelerated move near the right edge saturates instead of wrapping.
  function automatic logic [9:0] clamp(input logic signed [12:0] v, input int mx);
    return v < 13'sd0 ? 10'd0 : v > 13'(mx) ? 10'(mx) : v[9:0];
  endfunction
endpackage

// File: rtl/mouse_decoder_ps2_rx.sv
// ps2_rx: synchronizes and deglitches PS/2 clock/data, deserializes 11-bit frames with parity, stop and timeout checks.
module ps2_rx import mouse_pkg::*; #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] clk_s, dat_s;
  logic filt, par_ok, d, strobe, to, flip;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  rx_state_t state, nxt;
  assign d      = dat_s[1];
  assign flip   = clk_s[1] != filt && fcnt == FW'(FILTER_LEN - 1);
  assign strobe = flip && filt;
  assign to     = state != IDLE && !strobe && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = to ? IDLE :
          !strobe ? state :
          state == IDLE ? (d ? IDLE : DATA) :
          state == DATA ? (bcnt == 3'd7 ? PARITY : DATA) :
          state == PARITY ? STOP : IDLE;
  always_comb begin
    byte_valid = state == STOP && strobe && d && par_ok;
    byte_err   = to || (state == STOP && strobe && !(d && par_ok));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_s   <= '0;
      dat_s   <= '0;
      filt    <= 1'b0;
      fcnt    <= '0;
      tcnt    <= '0;
      bcnt    <= '0;
      par_ok  <= 1'b0;
      rx_byte <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      dat_s  <= {dat_s[0], ps2_data};
      fcnt   <= (clk_s[1] == filt || flip) ? '0 : fcnt + 1'b1;
      filt   <= flip ? clk_s[1] : filt;
      tcnt   <= (strobe || state == IDLE) ? '0 : tcnt + 1'b1;
      bcnt   <= state == IDLE ? 3'd0 : (state == DATA && strobe) ? bcnt + 3'd1 : bcnt;
      rx_byte <= (state == DATA && strobe) ? {d, rx_byte[7:1]} : rx_byte;
      par_ok <= (state == PARITY && strobe) ? ^{d, rx_byte} : par_ok;
    end
endmodule

// File: rtl/mouse_decoder.sv
// mouse_decoder: assembles 3-byte PS/2 mouse packets into a clamped absolute cursor and left-button click.
// Build with MOUSE_ACCEL_EN to double large motion deltas.
module mouse_decoder import mouse_pkg::*; #(
  parameter int X_MAX       = H_RES - 1,
  parameter int Y_MAX       = V_RES - 1,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       click,
  output logic       click_pulse,
  output logic       packet_valid,
  output logic       err
);
  logic [7:0] rx_byte, b1;
  logic rx_valid, rx_err, commit;
  logic [1:0] idx;
  hdr_t hdr;
  logic signed [10:0] dx, dy;
  logic signed [12:0] xs, ys;
  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk(clk), .rst(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .byte_valid(rx_valid), .byte_err(rx_err)
  );
  // Byte 2 is used straight off the receiver so the commit lands one clk after its stop strobe.
  always_comb begin
    commit = rx_valid && idx == 2'd2;
    dx = delta(hdr.xovf, hdr.xsign, b1);
    dy = delta(hdr.yovf, hdr.ysign, rx_byte);
    xs = 13'(signed'({1'b0, x})) + 13'(dx);
    ys = 13'(signed'({2'b0, y})) - 13'(dy);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx          <= '0;
      hdr          <= '0;
      b1           <= '0;
      x            <= 10'(X_INIT);
      y            <= 9'(Y_INIT);
      click        <= 1'b0;
      click_pulse  <= 1'b0;
      packet_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      err          <= rx_err;
      packet_valid <= commit;
      click_pulse  <= commit && !click && hdr.lbtn;
      if (rx_err) idx <= '0;
      else if (rx_valid) begin
        if (idx == 2'd0 && rx_byte[SYNC]) begin
          hdr <= '{rx_byte[YOVF], rx_byte[XOVF], rx_byte[YSIGN], rx_byte[XSIGN], rx_byte[LBTN]};
          idx <= 2'd1;
        end
        if (idx == 2'd1) begin
          b1  <= rx_byte;
          idx <= 2'd2;
        end
        if (commit) begin
          idx   <= 2'd0;
          x     <= clamp(xs, X_MAX);
          y     <= 9'(clamp(ys, Y_MAX));
          click <= hdr.lbtn;
        end
      end
    end
endmodule

// File: tb/tb_mouse_decoder.sv
// tb_mouse_decoder: vector table, directed corner sequences and a random packet stream against a behavioural cursor model.
module tb_mouse_decoder;
  localparam int TO = 3000;
`ifdef MOUSE_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  typedef struct {
    logic [7:0] b0, b1, b2;
    int x, xa, y;
    bit clk_lvl, pulse;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [9:0] x;
  logic [8:0] y;
  logic click, click_pulse, packet_valid, err;
  int n_checks = 0, n_fail = 0, n_pv = 0, n_err = 0, n_cp = 0, n_both = 0;
  int pv_x, pv_y, pv_click;
  int p0, e0, c0, mx, my, exp_pulse;
  bit mc;
  logic [7:0] r0, r1, r2;
  vec_t tbl[16];

  always #5 clk = ~clk;

  mouse_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .x(x), .y(y), .click(click), .click_pulse(click_pulse),
    .packet_valid(packet_valid), .err(err)
  );

  always @(negedge clk)
    if (!reset) begin
      if (packet_valid) begin
        n_pv++;
        pv_x = x;
        pv_y = y;
        pv_click = click;
      end
      if (err) n_err++;
      if (click_pulse) n_cp++;
      if (packet_valid && err) n_both++;
    end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (5) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (15) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad = 1'b0);
    logic [10:0] f;
    f = {1'b1, ~^b ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic snap();
    p0 = n_pv;
    e0 = n_err;
    c0 = n_cp;
  endtask

  // Cursor model: plain integer arithmetic straight from the packet format.
  task automatic model_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int dx, dy;
    dx = a[6] ? 0 : (a[4] ? int'(b) - 256 : int'(b));
    dy = a[7] ? 0 : (a[5] ? int'(c) - 256 : int'(c));
    if (ACC && (dx > 15 || dx < -15)) dx = dx * 2;
    if (ACC && (dy > 15 || dy < -15)) dy = dy * 2;
    mx = mx + dx;
    my = my - dy;
    mx = mx < 0 ? 0 : (mx > 639 ? 639 : mx);
    my = my < 0 ? 0 : (my > 479 ? 479 : my);
    exp_pulse = (!mc && a[0]) ? 1 : 0;
    mc = a[0];
  endtask

  initial begin
    tbl[0]  = '{8'h08, 8'h0A, 8'h05, 330, 330, 235, 1'b0, 1'b0};
    tbl[1]  = '{8'h09, 8'h00, 8'h00, 330, 330, 235, 1'b1, 1'b1};
    tbl[2]  = '{8'h09, 8'h00, 8'h00, 330, 330, 235, 1'b1, 1'b0};
    tbl[3]  = '{8'h08, 8'h00, 8'h00, 330, 330, 235, 1'b0, 1'b0};
    tbl[4]  = '{8'h18, 8'h00, 8'h00, 74,  0,   235, 1'b0, 1'b0};
    tbl[5]  = '{8'h18, 8'h00, 8'h00, 0,   0,   235, 1'b0, 1'b0};
    tbl[6]  = '{8'h08, 8'h05, 8'hFF, 5,   5,   0,   1'b0, 1'b0};
    tbl[7]  = '{8'h28, 8'h00, 8'hFB, 5,   5,   5,   1'b0, 1'b0};
    tbl[8]  = '{8'h18, 8'hF0, 8'h00, 0,   0,   5,   1'b0, 1'b0};
    tbl[9]  = '{8'h08, 8'hFF, 8'h00, 255, 510, 5,   1'b0, 1'b0};
    tbl[10] = '{8'h08, 8'hFF, 8'h00, 510, 639, 5,   1'b0, 1'b0};
    tbl[11] = '{8'h08, 8'hFF, 8'h00, 639, 639, 5,   1'b0, 1'b0};
    tbl[12] = '{8'h18, 8'hFC, 8'h00, 635, 635, 5,   1'b0, 1'b0};
    tbl[13] = '{8'h08, 8'h14, 8'h00, 639, 639, 5,   1'b0, 1'b0};
    tbl[14] = '{8'h48, 8'h50, 8'h03, 639, 639, 2,   1'b0, 1'b0};
    tbl[15] = '{8'h98, 8'hFB, 8'h80, 634, 634, 2,   1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", x, 320);
    check("rst_y", y, 240);
    check("rst_click", click, 0);
    check("rst_pv", packet_valid, 0);
    check("rst_err", err, 0);
    do_reset();
    check("idle_pv", n_pv, 0);

    for (int i = 0; i < 16; i++) begin
      snap();
      send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2);
      check($sformatf("tbl%0d_pv", i), n_pv - p0, 1);
      check($sformatf("tbl%0d_err", i), n_err - e0, 0);
      check($sformatf("tbl%0d_x", i), pv_x, ACC ? tbl[i].xa : tbl[i].x);
      check($sformatf("tbl%0d_y", i), pv_y, tbl[i].y);
      check($sformatf("tbl%0d_click", i), pv_click, int'(tbl[i].clk_lvl));
      check($sformatf("tbl%0d_pulse", i), n_cp - c0, int'(tbl[i].pulse));
    end

    // Bad parity on byte 1 abandons the packet; the next clean packet starts from index 0.
    do_reset();
    snap();
    send_byte(8'h08);
    send_byte(8'h0A, 1'b1);
    check("par_err", n_err - e0, 1);
    check("par_pv", n_pv - p0, 0);
    send_pkt(8'h08, 8'h01, 8'h00);
    check("par_next_pv", n_pv - p0, 1);
    check("par_next_x", pv_x, 321);

    // Stalled frame: timeout must not fire early, then fires once and clears the byte index.
    do_reset();
    snap();
    send_byte(8'h08);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (TO - 100) @(posedge clk);
    check("to_early", n_err - e0, 0);
    repeat (300) @(posedge clk);
    check("to_err", n_err - e0, 1);
    check("to_pv", n_pv - p0, 0);
    send_byte(8'h00);
    send_pkt(8'h08, 8'h02, 8'h00);
    check("to_next_pv", n_pv - p0, 1);
    check("to_next_x", pv_x, 322);
    check("to_next_y", pv_y, 240);

    // Reset between byte 1 and byte 2 restores the home position and drops the partial packet.
    do_reset();
    send_pkt(8'h08, 8'h0A, 8'h05);
    check("mid_pre_x", x, 330);
    send_byte(8'h08);
    send_byte(8'h0A);
    repeat (5) @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_x", x, 320);
    check("mid_rst_y", y, 240);
    repeat (3) @(posedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    snap();
    send_byte(8'h05);
    repeat (10) @(posedge clk);
    check("mid_lone_pv", n_pv - p0, 0);
    send_pkt(8'h48, 8'h50, 8'h03);
    check("xovf_pv", n_pv - p0, 1);
    check("xovf_x", pv_x, 320);
    check("xovf_y", pv_y, 237);

    // Random packets, with occasional unsynchronized lone bytes that must be dropped.
    do_reset();
    mx = 320;
    my = 240;
    mc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      snap();
      if ($urandom_range(0, 4) == 0) begin
        r0[3] = 1'b0;
        send_byte(r0);
        check($sformatf("rnd%0d_drop", i), n_pv - p0, 0);
      end else begin
        r0[3] = 1'b1;
        send_pkt(r0, r1, r2);
        model_pkt(r0, r1, r2);
        check($sformatf("rnd%0d_pv", i), n_pv - p0, 1);
        check($sformatf("rnd%0d_x", i), pv_x, mx);
        check($sformatf("rnd%0d_y", i), pv_y, my);
        check($sformatf("rnd%0d_click", i), pv_click, int'(mc));
        check($sformatf("rnd%0d_pulse", i), n_cp - c0, exp_pulse);
      end
      check($sformatf("rnd%0d_err", i), n_err - e0, 0);
    end

    check("pv_err_overlap", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
